clink_frame_packer: RTL and testbench
=====================================

# clink_frame_packer

Packs the deserialised Camera Link base-configuration pixel stream (three 8-bit taps d0/d1/d2 qualified by fval/lval/dval) into 96-bit AXI4-Stream beats. It captures exactly one whole frame per arm request. It sits directly downstream of the Camera Link interface/deserialiser and upstream of the frame DMA. The camera cannot be back-pressured, so the block decouples the two sides with a small FIFO and reports loss through sticky status flags.

## Interface
- FIFO_DEPTH, 4: output FIFO depth in 96-bit words; must be a power of 2 and ≥2.
- FRAME_CNT_W, 16: width of frame_count.
- clink_X_clk_out  in  1: pixel clock. One clock only; all logic runs on this clock.
- s_axi_aresetn  in  1: reset, asynchronous, active-low.
- d0, d1, d2  in  8 each: tap pixels; d0 is the earliest pixel.
- fval, lval, dval  in  1 each: frame, line and data valid.
- clink_X_ready  in  1: deserialiser locked/aligned.
- arm  in  1: single-cycle pulse requesting capture of the next complete frame; also clears the sticky flags.
- m_axis_tdata  out  96: 12 pixels per beat.
- m_axis_tvalid  out  1; m_axis_tready  in  1.
- m_axis_tuser  out  1: first beat of frame.
- m_axis_tlast  out  1: last beat of frame.
- image_end  out  1: one-cycle pulse marking frame completion.
- busy  out  1: state ≠ IDLE or FIFO not empty.
- frame_count  out  FRAME_CNT_W: number of completed frames; wraps.
- overflow, partial, aborted  out  1 each: sticky error flags.

## Operation
- States:
  - IDLE: waiting for arm.
  - SYNC: waiting for fval=0.
  - WAIT_SOF: waiting for fval=1.
  - CAPTURE: accumulating pixels.
- Transitions:
  - IDLE→SYNC on arm.
  - SYNC→WAIT_SOF when fval=0 is sampled.
  - WAIT_SOF→CAPTURE when fval=1 is sampled.
  - CAPTURE→IDLE when fval=0 is sampled, or when clink_X_ready=0.
  - arm outside IDLE is ignored except that it clears the flags.
- Beat accumulation in CAPTURE: each cycle with fval&lval&dval is a pixel cycle, tracked by a 2-bit phase k.
  - Cycle k writes the accumulator bits [24k+23:24k] as {d2,d1,d0}.
  - When k=3 completes, the word is full and the phase returns to 0.
- Pending register: each full word moves into a one-word pending register. Any previously pending word is pushed to the FIFO with tlast=0 at that moment.
  - The first word of a frame carries tuser=1.
- Line end: if lval falls with k≠0, the partial word is zero-padded, treated as full, and partial is set.
- Frame end (fval sampled 0 in CAPTURE):
  - A partial accumulator is padded first, as for line end.
  - The pending word is pushed with tlast=1.
  - If no word was ever produced (empty frame), nothing is pushed and image_end pulses immediately.
- Abort (clink_X_ready=0 in CAPTURE):
  - The pending word is pushed with tlast=1; the accumulator is discarded.
  - aborted is set; image_end is not pulsed; frame_count is not incremented.
- FIFO: first-word-fall-through.
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the word is dropped and overflow is set.
  - A dropped tlast word means the frame has no tlast, and image_end pulses at the fval fall instead.
- image_end: pulses the cycle after the tlast beat handshakes (tvalid&tready&tlast) for non-aborted frames. frame_count increments in the same cycle.
- Pixels outside CAPTURE are ignored.

## Timing
- Reset values: state IDLE; all outputs 0 (tvalid, tuser, tlast, image_end, busy, frame_count, all flags); FIFO empty; phase 0.
- Reset mid-frame: everything is discarded immediately, with no tlast emitted.
- Latency from the 4th pixel cycle of word N to the word entering the FIFO:
  - the edge that completes word N+1, or
  - the edge at which fval=0 is sampled, for the last word.
- m_axis_tvalid rises one cycle after a push into an empty FIFO.
- AXI-Stream rules:
  - tdata, tuser and tlast stay stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
- Simultaneous events:
  - Line end and frame end in the same cycle: pad once, then push with tlast=1.
  - Full word completing and fval falling together cannot occur, because a pixel cycle needs fval=1.
- Throughput: 1 beat per 4 pixel clocks in; 1 beat per clock out.

## Test plan
- Arm, then a 2-line frame of 24 pixel cycles per line with pixel bytes incrementing from 0x00 and tready=1 → 12 beats:
  - beat0 tdata[23:0]=0x020100 with tuser=1;
  - beat11 has tlast=1;
  - image_end pulses once; frame_count=1.
- Arm while fval=1 mid-frame → no output until the next frame starts; the frame is then captured whole, and only one frame is captured.
- Line of 6 pixel cycles → 2 beats:
  - the second beat has bits [95:48]=0;
  - partial=1.
- tready=0 during a 16-beat frame with FIFO_DEPTH=4 → overflow=1, 5 beats delivered once tready=1, and image_end still pulses at the fval fall.
- clink_X_ready drops after 9 pixel cycles → 2 beats, the second with tlast=1; aborted=1; no image_end; frame_count unchanged.
- s_axi_aresetn asserted mid-frame → tvalid=0 and state IDLE immediately; a later arm captures a clean frame with tuser=1.

Source files
------------

// File: rtl/clink_frame_packer.sv
// clink_frame_packer
//
// Packs the Camera Link base-configuration pixel stream (three 8-bit taps
// per clock, qualified by fval/lval/dval) into 96-bit AXI4-Stream beats of
// 12 pixels each. One arm request captures exactly one whole frame. The
// camera cannot be stalled, so a small first-word-fall-through FIFO
// decouples the two sides. Lost data is reported through sticky flags.
//
// Ports
//   clink_X_clk_out  pixel clock; the only clock in the block
//   s_axi_aresetn    asynchronous active-low reset
//   d0, d1, d2       tap pixels; d0 is the earliest pixel
//   fval/lval/dval   frame, line and data valid
//   clink_X_ready    deserialiser locked; a low level aborts a capture
//   arm              pulse: capture the next whole frame, clear sticky flags
//   m_axis_*         96-bit AXI4-Stream master (tuser = first beat,
//                    tlast = last beat of the frame)
//   image_end        one-cycle pulse when a frame has completed
//   busy             capture in progress or output data still queued
//   frame_count      completed frames, wrapping
//   overflow         a word was dropped because the FIFO was full
//   partial          a line ended part-way through a word (zero-padded)
//   aborted          capture was cut short by clink_X_ready falling
module clink_frame_packer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clink_X_clk_out,
  input  logic                   s_axi_aresetn,
  input  logic [7:0]             d0,
  input  logic [7:0]             d1,
  input  logic [7:0]             d2,
  input  logic                   fval,
  input  logic                   lval,
  input  logic                   dval,
  input  logic                   clink_X_ready,
  input  logic                   arm,
  output logic [95:0]            m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   image_end,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   overflow,
  output logic                   partial,
  output logic                   aborted
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SYNC     = 2'd1;
  localparam logic [1:0] WAIT_SOF = 2'd2;
  localparam logic [1:0] CAPTURE  = 2'd3;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // FIFO entry: {no_end, last, user, data}. no_end marks the tlast word of an
  // aborted frame, whose handshake must not produce image_end.
  localparam int EW = 99;

  logic [1:0]    state, state_nxt;
  logic [1:0]    phase;
  logic [95:0]   acc;
  logic [95:0]   pend_data;
  logic          pend_user;
  logic          pend_valid;
  logic          first_word;
  logic          flush;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          out_noend;

  logic          pix;
  logic          push_en;
  logic [EW-1:0] push_entry;
  logic          pend_load;
  logic          pend_clear;
  logic [95:0]   new_word;
  logic          acc_clear;
  logic          pix_store;
  logic          set_partial;
  logic          set_aborted;
  logic          empty_end;
  logic          end_push;
  logic          flush_set;
  logic          pop;
  logic          accept;
  logic          drop;
  logic          hs_end;
  logic          frame_done;

  assign pix = fval & lval & dval;

  // Capture control. Decides, for this cycle, the next state, what happens
  // to the accumulator and the pending word, and what (if anything) is
  // offered to the FIFO. A pending word is only pushed once its successor
  // exists or the frame ends, so the frame's final word can carry tlast.
  // When a partial word is padded at frame end while another word is still
  // pending, two words become ready together; the older goes out now and the
  // padded one is held for one more cycle (flush) and pushed with tlast.
  always_comb begin
    state_nxt   = state;
    push_en     = 1'b0;
    push_entry  = '0;
    pend_load   = 1'b0;
    pend_clear  = 1'b0;
    new_word    = '0;
    acc_clear   = 1'b0;
    pix_store   = 1'b0;
    set_partial = 1'b0;
    set_aborted = 1'b0;
    empty_end   = 1'b0;
    end_push    = 1'b0;
    flush_set   = 1'b0;

    if (flush) begin
      push_en    = 1'b1;
      push_entry = {1'b0, 1'b1, pend_user, pend_data};
      pend_clear = 1'b1;
      end_push   = 1'b1;
    end

    case (state)
      IDLE: begin
        if (arm) state_nxt = SYNC;
      end
      SYNC: begin
        if (!fval) state_nxt = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (fval) state_nxt = CAPTURE;
      end
      default: begin
        if (!clink_X_ready) begin
          state_nxt   = IDLE;
          set_aborted = 1'b1;
          acc_clear   = 1'b1;
          if (pend_valid) begin
            push_en    = 1'b1;
            push_entry = {1'b1, 1'b1, pend_user, pend_data};
            pend_clear = 1'b1;
          end
        end else if (!fval) begin
          state_nxt = IDLE;
          acc_clear = 1'b1;
          if (phase != 2'd0) begin
            set_partial = 1'b1;
            if (pend_valid) begin
              push_en    = 1'b1;
              push_entry = {1'b0, 1'b0, pend_user, pend_data};
              pend_load  = 1'b1;
              new_word   = acc;
              flush_set  = 1'b1;
            end else begin
              push_en    = 1'b1;
              push_entry = {1'b0, 1'b1, first_word, acc};
              end_push   = 1'b1;
            end
          end else if (pend_valid) begin
            push_en    = 1'b1;
            push_entry = {1'b0, 1'b1, pend_user, pend_data};
            pend_clear = 1'b1;
            end_push   = 1'b1;
          end else begin
            empty_end = 1'b1;
          end
        end else if ((pix && phase == 2'd3) || (!lval && phase != 2'd0)) begin
          // Word complete: either the fourth pixel arrived, or the line
          // ended early and the zero-filled remainder of acc is the padding.
          acc_clear   = 1'b1;
          set_partial = !pix;
          pend_load   = 1'b1;
          new_word    = pix ? {d2, d1, d0, acc[71:0]} : acc;
          if (pend_valid) begin
            push_en    = 1'b1;
            push_entry = {1'b0, 1'b0, pend_user, pend_data};
          end
        end else if (pix) begin
          pix_store = 1'b1;
        end
      end
    endcase
  end

  // A push into a full FIFO still succeeds if a word leaves in the same
  // cycle; otherwise it is dropped. pop moves the head into the output
  // register, which is why tvalid follows a push by one cycle.
  assign pop        = (count != '0) && (!m_axis_tvalid || m_axis_tready);
  assign accept     = push_en && ((count != DEPTH_C) || pop);
  assign drop       = push_en && !accept;
  assign hs_end     = m_axis_tvalid && m_axis_tready && m_axis_tlast && !out_noend;
  // A frame whose tlast word was dropped completes at the fval fall instead.
  assign frame_done = hs_end || empty_end || (drop && end_push);

  assign busy = (state != IDLE) || (count != '0) || m_axis_tvalid || flush || pend_valid;

  // FIFO storage; contents need no reset because count/pointers define them.
  always_ff @(posedge clink_X_clk_out) begin
    if (accept) mem[wr_ptr] <= push_entry;
  end

  // Capture datapath, FIFO pointers, output register and status.
  always_ff @(posedge clink_X_clk_out or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state         <= IDLE;
      phase         <= 2'd0;
      acc           <= '0;
      pend_data     <= '0;
      pend_user     <= 1'b0;
      pend_valid    <= 1'b0;
      first_word    <= 1'b0;
      flush         <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      out_noend     <= 1'b0;
      image_end     <= 1'b0;
      frame_count   <= '0;
      overflow      <= 1'b0;
      partial       <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      state <= state_nxt;
      flush <= flush_set;

      if (state == WAIT_SOF && fval) first_word <= 1'b1;
      else if (pend_load)             first_word <= 1'b0;

      if (acc_clear) begin
        acc   <= '0;
        phase <= 2'd0;
      end else if (pix_store) begin
        case (phase)
          2'd0:    acc[23:0]  <= {d2, d1, d0};
          2'd1:    acc[47:24] <= {d2, d1, d0};
          default: acc[71:48] <= {d2, d1, d0};
        endcase
        phase <= phase + 2'd1;
      end

      if (pend_load) begin
        pend_valid <= 1'b1;
        pend_data  <= new_word;
        pend_user  <= first_word;
      end else if (pend_clear) begin
        pend_valid <= 1'b0;
      end

      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        {out_noend, m_axis_tlast, m_axis_tuser, m_axis_tdata} <= mem[rd_ptr];
        m_axis_tvalid <= 1'b1;
        rd_ptr        <= rd_ptr + 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tuser  <= 1'b0;
        m_axis_tlast  <= 1'b0;
        out_noend     <= 1'b0;
      end

      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      image_end <= frame_done;
      if (frame_done) frame_count <= frame_count + 1'b1;

      // arm clears the sticky flags, but an event in the same cycle wins.
      overflow <= (overflow && !arm) || drop;
      partial  <= (partial  && !arm) || set_partial;
      aborted  <= (aborted  && !arm) || set_aborted;
    end
  end

endmodule

// File: tb/tb_clink_frame_packer.sv
// tb_clink_frame_packer
//
// Drives randomised Camera Link frames into clink_frame_packer and compares
// the AXI-Stream beats, image_end pulses, frame_count and sticky flags with
// a reference built directly from the frame's line lengths and pixel list.
`timescale 1ns/1ps
module tb_clink_frame_packer;

  localparam int FIFO_DEPTH  = 4;
  localparam int FRAME_CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [7:0]             d0, d1, d2;
  logic                   fval, lval, dval;
  logic                   camReady;
  logic                   arm;
  logic [95:0]            tdata;
  logic                   tvalid, tready, tuser, tlast;
  logic                   imageEnd, busy;
  logic [FRAME_CNT_W-1:0] frameCount;
  logic                   overflow, partial, aborted;

  always #5 clk = ~clk;

  clink_frame_packer #(.FIFO_DEPTH(FIFO_DEPTH), .FRAME_CNT_W(FRAME_CNT_W)) dut (
    .clink_X_clk_out(clk),
    .s_axi_aresetn  (rst_n),
    .d0             (d0),
    .d1             (d1),
    .d2             (d2),
    .fval           (fval),
    .lval           (lval),
    .dval           (dval),
    .clink_X_ready  (camReady),
    .arm            (arm),
    .m_axis_tdata   (tdata),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tuser   (tuser),
    .m_axis_tlast   (tlast),
    .image_end      (imageEnd),
    .busy           (busy),
    .frame_count    (frameCount),
    .overflow       (overflow),
    .partial        (partial),
    .aborted        (aborted)
  );

  typedef struct {
    logic [95:0] data;
    logic        user;
    logic        last;
  } beat_t;

  beat_t       gotQ[$];
  beat_t       expQ[$];
  beat_t       colBeat;
  logic [23:0] pix[$];
  int          lens[$];
  int          imgEnds = 0;
  int          readyMode = 1;
  int          expFrames = 0;
  int          assertCount = 0;
  int          failCount = 0;

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Collects handshaken beats and image_end pulses between clock edges.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tvalid && tready) begin
        colBeat.data = tdata;
        colBeat.user = tuser;
        colBeat.last = tlast;
        gotQ.push_back(colBeat);
      end
      if (imageEnd) imgEnds++;
    end
  end

  // Sink back-pressure: 0 = stalled, 1 = always ready, 2 = ready 75%.
  initial begin
    tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (readyMode == 0)      tready = 1'b0;
      else if (readyMode == 1) tready = 1'b1;
      else                     tready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit expPartial();
    foreach (lens[l]) if (lens[l] % 4 != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic genFrame(input int nLines, input int fixedLen, input bit inc);
    int len;
    int n;
    lens.delete();
    pix.delete();
    n = 0;
    for (int l = 0; l < nLines; l++) begin
      len = (fixedLen > 0) ? fixedLen : $urandom_range(1, 20);
      lens.push_back(len);
      for (int i = 0; i < len; i++) begin
        if (inc) pix.push_back({8'(3*n+2), 8'(3*n+1), 8'(3*n)});
        else     pix.push_back(24'($urandom));
        n++;
      end
    end
  endtask

  // Reference: each line is cut into groups of four pixel cycles, the last
  // group zero-filled; an abort keeps only the groups finished before it.
  task automatic buildExpected(input int abortAfter);
    int          idx;
    bit          stop;
    logic [95:0] w;
    beat_t       b;
    expQ.delete();
    idx  = 0;
    stop = 1'b0;
    for (int l = 0; l < lens.size() && !stop; l++) begin
      w = '0;
      for (int j = 0; j < lens[l]; j++) begin
        if (abortAfter >= 0 && idx == abortAfter) begin
          stop = 1'b1;
          break;
        end
        w = w | (96'(pix[idx]) << (24 * (j % 4)));
        idx++;
        if (j % 4 == 3 || j == lens[l] - 1) begin
          b.data = w;
          b.user = 1'b0;
          b.last = 1'b0;
          expQ.push_back(b);
          w = '0;
        end
      end
    end
    if (expQ.size() > 0) begin
      b = expQ[0];
      b.user = 1'b1;
      expQ[0] = b;
      b = expQ[expQ.size()-1];
      b.last = 1'b1;
      expQ[expQ.size()-1] = b;
    end
  endtask

  // Plays the current frame. armAt: -1 arm before the frame, -2 no arm,
  // >=0 arm on that pixel cycle. abortAt/resetAt: pixel index at which the
  // deserialiser drops or reset is asserted (-1 = never).
  task automatic applyStimulus(input int armAt, input int abortAt, input int resetAt,
                               input bit gaps, input bit fallTogether);
    int idx;
    idx = 0;
    fval = 1'b0; lval = 1'b0; dval = 1'b0; camReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      arm = (armAt == -1 && c == 1);
      tick();
      arm = 1'b0;
    end
    fval = 1'b1;
    tick();
    tick();
    for (int l = 0; l < lens.size(); l++) begin
      lval = 1'b1;
      for (int j = 0; j < lens[l]; j++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          dval = 1'b0;
          {d2, d1, d0} = 24'($urandom);
          tick();
        end
        if (idx == resetAt) begin
          rst_n = 1'b0;
          #1;
          checkOutput("rst_mid_tvalid", tvalid, 1'b0);
          checkOutput("rst_mid_busy", busy, 1'b0);
          fval = 1'b0; lval = 1'b0; dval = 1'b0;
          return;
        end
        if (idx == abortAt) begin
          camReady = 1'b0;
          dval = 1'b1;
          {d2, d1, d0} = 24'($urandom);
          tick();
          camReady = 1'b1;
        end
        arm  = (idx == armAt);
        dval = 1'b1;
        {d2, d1, d0} = pix[idx];
        tick();
        arm  = 1'b0;
        dval = 1'b0;
        idx++;
      end
      if (l == lens.size() - 1 && fallTogether) begin
        lval = 1'b0;
        fval = 1'b0;
        tick();
      end else begin
        lval = 1'b0;
        tick();
        tick();
      end
    end
    fval = 1'b0;
    repeat (4) tick();
  endtask

  task automatic waitIdle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    checkOutput({tag, "_idle"}, busy, 1'b0);
    repeat (3) tick();
  endtask

  task automatic compareBeats(input string tag);
    checkOutput({tag, "_count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), gotQ[i].data, expQ[i].data);
      checkOutput($sformatf("%s_user%0d", tag, i), gotQ[i].user, expQ[i].user);
      checkOutput($sformatf("%s_last%0d", tag, i), gotQ[i].last, expQ[i].last);
    end
  endtask

  task automatic clearCollect();
    gotQ.delete();
    imgEnds = 0;
  endtask

  initial begin
    bit    expP;
    beat_t b;
    rst_n = 1'b0; arm = 1'b0; fval = 1'b0; lval = 1'b0; dval = 1'b0;
    camReady = 1'b1; d0 = '0; d1 = '0; d2 = '0;
    readyMode = 1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tvalid", tvalid, 1'b0);
    checkOutput("reset_tuser", tuser, 1'b0);
    checkOutput("reset_tlast", tlast, 1'b0);
    checkOutput("reset_image_end", imageEnd, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_frame_count", frameCount, 0);
    checkOutput("reset_overflow", overflow, 1'b0);
    checkOutput("reset_partial", partial, 1'b0);
    checkOutput("reset_aborted", aborted, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();

    $display("[TB] incrementing 2x24 frame");
    clearCollect();
    genFrame(2, 24, 1'b1);
    buildExpected(-1);
    applyStimulus(-1, -1, -1, 1'b0, 1'b0);
    waitIdle("inc", 200);
    expFrames++;
    compareBeats("inc");
    if (gotQ.size() > 0) checkOutput("inc_beat0_low", gotQ[0].data[23:0], 24'h020100);
    checkOutput("inc_image_end", imgEnds, 1);
    checkOutput("inc_frame_count", frameCount, expFrames);
    checkOutput("inc_partial", partial, 1'b0);

    $display("[TB] arm during a frame");
    clearCollect();
    genFrame(2, 8, 1'b0);
    applyStimulus(5, -1, -1, 1'b1, 1'b0);
    genFrame(2, 0, 1'b0);
    buildExpected(-1);
    expP = expPartial();
    applyStimulus(-2, -1, -1, 1'b1, 1'b0);
    genFrame(2, 0, 1'b0);
    applyStimulus(-2, -1, -1, 1'b1, 1'b0);
    waitIdle("midarm", 200);
    expFrames++;
    compareBeats("midarm");
    checkOutput("midarm_image_end", imgEnds, 1);
    checkOutput("midarm_frame_count", frameCount, expFrames);
    checkOutput("midarm_partial", partial, expP);

    $display("[TB] random frames");
    readyMode = 2;
    for (int f = 0; f < 4; f++) begin
      clearCollect();
      genFrame($urandom_range(1, 3), 0, 1'b0);
      buildExpected(-1);
      expP = expPartial();
      applyStimulus(-1, -1, -1, 1'b1, 1'($urandom_range(0, 1)));
      waitIdle($sformatf("rnd%0d", f), 300);
      expFrames++;
      compareBeats($sformatf("rnd%0d", f));
      checkOutput($sformatf("rnd%0d_image_end", f), imgEnds, 1);
      checkOutput($sformatf("rnd%0d_frame_count", f), frameCount, expFrames);
      checkOutput($sformatf("rnd%0d_partial", f), partial, expP);
      checkOutput($sformatf("rnd%0d_overflow", f), overflow, 1'b0);
    end

    $display("[TB] short line of 6 pixel cycles");
    readyMode = 1;
    clearCollect();
    genFrame(1, 6, 1'b0);
    buildExpected(-1);
    applyStimulus(-1, -1, -1, 1'b0, 1'b1);
    waitIdle("short", 200);
    expFrames++;
    compareBeats("short");
    if (gotQ.size() > 1) checkOutput("short_pad", gotQ[1].data[95:48], 48'h0);
    checkOutput("short_partial", partial, 1'b1);
    checkOutput("short_image_end", imgEnds, 1);

    $display("[TB] stalled sink, 16-beat frame");
    readyMode = 0;
    clearCollect();
    genFrame(2, 32, 1'b0);
    buildExpected(-1);
    while (expQ.size() > 5) void'(expQ.pop_back());
    for (int i = 0; i < expQ.size(); i++) begin
      b = expQ[i];
      b.last = 1'b0;
      expQ[i] = b;
    end
    applyStimulus(-1, -1, -1, 1'b0, 1'b0);
    repeat (5) tick();
    expFrames++;
    checkOutput("ovf_held", gotQ.size(), 0);
    checkOutput("ovf_image_end", imgEnds, 1);
    checkOutput("ovf_frame_count", frameCount, expFrames);
    checkOutput("ovf_flag", overflow, 1'b1);
    readyMode = 1;
    waitIdle("ovf", 100);
    compareBeats("ovf");
    checkOutput("ovf_image_end_after", imgEnds, 1);

    $display("[TB] deserialiser drop after 9 pixel cycles");
    clearCollect();
    genFrame(1, 20, 1'b0);
    buildExpected(9);
    applyStimulus(-1, 9, -1, 1'b0, 1'b0);
    waitIdle("abort", 200);
    compareBeats("abort");
    checkOutput("abort_flag", aborted, 1'b1);
    checkOutput("abort_image_end", imgEnds, 0);
    checkOutput("abort_frame_count", frameCount, expFrames);

    $display("[TB] reset during a frame");
    readyMode = 0;
    clearCollect();
    genFrame(2, 24, 1'b0);
    applyStimulus(-1, -1, 20, 1'b0, 1'b0);
    tick();
    checkOutput("rst_frame_count", frameCount, 0);
    rst_n = 1'b1;
    tick();
    expFrames = 0;
    readyMode = 2;
    clearCollect();
    genFrame(2, 0, 1'b0);
    buildExpected(-1);
    applyStimulus(-1, -1, -1, 1'b1, 1'b0);
    waitIdle("post_rst", 300);
    expFrames++;
    compareBeats("post_rst");
    checkOutput("post_rst_frame_count", frameCount, expFrames);
    checkOutput("post_rst_image_end", imgEnds, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
